pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 138 +++++++++++++
 tb/tb_pc_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with trap/mret, misaligned-redirect detection and an optional
// return-address stack (compiled in only when PC_UNIT_RAS_EN is defined).
module pc_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] INITIAL_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0010,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            count,
  input  logic            load,
  input  logic [XLEN-1:0] value,
  input  logic            trap,
  input  logic            mret,
  input  logic            push,
  input  logic            pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_inc,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic            ras_empty
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic            pop_hit;
  logic [XLEN-1:0] ras_top;

  assign pc_inc     = pc_q + XLEN'(4);
  assign pc         = pc_q;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;

`ifdef PC_UNIT_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] OCC_FULL = (PW+1)'(RAS_DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     occ_q, occ_d;
  logic [PW-1:0]   top_idx;
  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic            accept;

  // Push/pop only take effect in cycles where nothing higher-priority owns the PC.
  assign accept    = !reset && !trap && !mret && !stall;
  assign top_idx   = wr_ptr_q - PW'(1);
  assign ras_empty = (occ_q == '0);
  assign pop_hit   = accept && pop && !ras_empty;
  assign ras_top   = ras_mem_q[top_idx];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    ras_we    = 1'b0;
    ras_waddr = wr_ptr_q;
    if (accept) begin
      if (push && pop_hit) begin
        ras_we    = 1'b1;
        ras_waddr = top_idx;
      end else if (push) begin
        // When full the write slot is the oldest entry, so it is overwritten in place.
        ras_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (occ_q != OCC_FULL) occ_d = occ_q + (PW+1)'(1);
      end else if (pop_hit) begin
        wr_ptr_d = top_idx;
        occ_d    = occ_q - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_mem_q[ras_waddr] <= pc_inc;
  end
`else
  logic ras_unused;

  assign ras_unused = push;
  assign pop_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    if (trap) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
    end else if (mret) begin
      pc_d = epc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (load) begin
      if (value[1:0] != 2'b00) begin
        pc_d         = TRAP_VECTOR;
        epc_d        = pc_q;
        misaligned_d = 1'b1;
      end else begin
        pc_d = value;
      end
    end else if (pop_hit) begin
      pc_d = ras_top;
    end else if (count || pop) begin
      // An empty-stack pop degrades to a plain sequential step.
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= INITIAL_PC;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus RAS sequences, checked
// through an expectation queue one cycle after each stimulus.
module tb_pc_unit;
  localparam int XLEN = 32;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, stall, count, load, trap, mret, push, pop;
  logic [XLEN-1:0] value;
  logic [XLEN-1:0] pc, pc_inc, epc;
  logic            misaligned, ras_empty;

  pc_unit #(
    .XLEN(XLEN),
    .INITIAL_PC(32'h0000_0100),
    .TRAP_VECTOR(32'h0000_0010),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .count(count), .load(load),
    .value(value), .trap(trap), .mret(mret), .push(push), .pop(pop),
    .pc(pc), .pc_inc(pc_inc), .epc(epc), .misaligned(misaligned),
    .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        emp;
  } exp_t;

  typedef struct {
    string       name;
    logic        r, st, c, l, t, m, pu, po;
    logic [31:0] v;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        emp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic drive(input logic r, st, c, l, t, m, pu, po, input logic [31:0] v);
    reset = r; stall = st; count = c; load = l; trap = t; mret = m;
    push = pu; pop = po; value = v;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] p, e,
                            input logic mis, emp);
    exp_t x;
    x.name = nm; x.pc = p; x.epc = e; x.mis = mis; x.emp = emp;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_underflow: no expectation queued");
      return;
    end
    x = sb.pop_front();
    if (pc !== x.pc || epc !== x.epc || misaligned !== x.mis || ras_empty !== x.emp) begin
      bad++;
      $display("FAIL %s: got pc=%h epc=%h mis=%b empty=%b, want pc=%h epc=%h mis=%b empty=%b",
               x.name, pc, epc, misaligned, ras_empty, x.pc, x.epc, x.mis, x.emp);
    end
    total++;
    if (pc_inc !== x.pc + 32'd4) begin
      bad++;
      $display("FAIL %s_pc_inc: got %h want %h", x.name, pc_inc, x.pc + 32'd4);
    end
  endtask

  // Apply one cycle of stimulus with its expected post-edge outputs.
  task automatic step(input string nm, input logic r, st, c, l, t, m, pu, po,
                      input logic [31:0] v, input logic [31:0] p, e,
                      input logic mis, emp);
    drive(r, st, c, l, t, m, pu, po, v);
    expect_out(nm, p, e, mis, emp);
    @(posedge clk);
    #1;
    check();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic add(input string nm, input logic r, st, c, l, t, m, pu, po,
                     input logic [31:0] v, input logic [31:0] p, e,
                     input logic mis, emp);
    vec_t x;
    x.name = nm; x.r = r; x.st = st; x.c = c; x.l = l; x.t = t; x.m = m;
    x.pu = pu; x.po = po; x.v = v; x.pc = p; x.epc = e; x.mis = mis; x.emp = emp;
    tbl.push_back(x);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    step("reset", 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h100, 32'h0, 0, 1);

    //  name          r  st c  l  t  m  pu po value          pc             epc         mis emp
    add("count1",     0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h104,       32'h0,      0, 1);
    add("count2",     0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h108,       32'h0,      0, 1);
    add("count3",     0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h10C,       32'h0,      0, 1);
    add("load_al",    0, 0, 0, 1, 0, 0, 0, 0, 32'h200,      32'h200,       32'h0,      0, 1);
    add("load_mis",   0, 0, 0, 1, 0, 0, 0, 0, 32'h202,      32'h10,        32'h200,    1, 1);
    add("mis_drop",   0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h10,        32'h200,    0, 1);
    add("load_300",   0, 0, 0, 1, 0, 0, 0, 0, 32'h300,      32'h300,       32'h200,    0, 1);
    add("trap_stall", 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h10,        32'h300,    0, 1);
    add("mret",       0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h300,       32'h300,    0, 1);
    add("stall_cnt",  0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h300,       32'h300,    0, 1);
    add("stall_load", 0, 1, 0, 1, 0, 0, 0, 0, 32'h500,      32'h300,       32'h300,    0, 1);
    add("trap_mret",  0, 0, 0, 0, 1, 1, 0, 0, 32'h0,        32'h10,        32'h300,    0, 1);
    add("load_top",   0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h300,   0, 1);
    add("wrap",       0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h300,    0, 1);
    add("stall_wrap", 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         32'h300,    0, 1);
    add("load_vs_cnt",0, 0, 1, 1, 0, 0, 0, 0, 32'h40,       32'h40,        32'h300,    0, 1);
    add("pop_empty",  0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h44,        32'h300,    0, 1);
    add("mret_load",  0, 0, 0, 1, 0, 1, 0, 0, 32'h80,       32'h300,       32'h300,    0, 1);
    add("stall_mis",  0, 1, 0, 1, 0, 0, 0, 0, 32'h1,        32'h300,       32'h300,    0, 1);
    add("load_mis2",  0, 0, 0, 1, 0, 0, 0, 0, 32'h1,        32'h10,        32'h300,    1, 1);
    add("push_cnt",   0, 0, 1, 0, 0, 0, 1, 0, 32'h0,        32'h14,        32'h300,    0, !RAS_ON);
    add("pop_after",  0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        RAS_ON ? 32'h14 : 32'h18, 32'h300, 0, 1);
    add("reset_ovr",  1, 0, 1, 0, 1, 0, 1, 0, 32'h0,        32'h100,       32'h0,      0, 1);
    add("post_reset", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h104,       32'h0,      0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].r, tbl[i].st, tbl[i].c, tbl[i].l, tbl[i].t, tbl[i].m,
           tbl[i].pu, tbl[i].po, tbl[i].v, tbl[i].pc, tbl[i].epc, tbl[i].mis, tbl[i].emp);
    end

`ifdef PC_UNIT_RAS_EN
    // Call then return.
    step("ras_go400",  0, 0, 0, 1, 0, 0, 0, 0, 32'h400, 32'h400, 32'h0, 0, 1);
    step("ras_call",   0, 0, 0, 1, 0, 0, 1, 0, 32'h800, 32'h800, 32'h0, 0, 0);
    step("ras_ret",    0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h404, 32'h0, 0, 1);

    // Overflow: five calls into a four-deep stack drop the oldest return address.
    step("ras_go0",    0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("ras_push%0d", i), 0, 0, 0, 1, 0, 0, 1, 0, 32'(i * 16),
           32'(i * 16), 32'h0, 0, 0);
    end
    step("ras_pop1",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h44, 32'h0, 0, 0);
    step("ras_pop2",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h34, 32'h0, 0, 0);
    step("ras_pop3",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h24, 32'h0, 0, 0);
    step("ras_pop4",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h14, 32'h0, 0, 1);
    step("ras_pop5",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h18, 32'h0, 0, 1);

    // Stalled push/pop are ignored.
    step("ras_stpush", 0, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h18, 32'h0, 0, 1);

    // Simultaneous push+pop swaps the top entry.
    step("ras_go600",  0, 0, 0, 1, 0, 0, 0, 0, 32'h600, 32'h600, 32'h0, 0, 1);
    step("ras_call2",  0, 0, 0, 1, 0, 0, 1, 0, 32'h700, 32'h700, 32'h0, 0, 0);
    step("ras_swap",   0, 0, 0, 0, 0, 0, 1, 1, 32'h0,   32'h604, 32'h0, 0, 0);
    step("ras_ret2",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h704, 32'h0, 0, 1);
`else
    // Without the stack, push is ignored and pop is a plain step.
    step("nras_push",  0, 0, 0, 1, 0, 0, 1, 0, 32'h800, 32'h800, 32'h0, 0, 1);
    step("nras_pop",   0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h804, 32'h0, 0, 1);
`endif

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
